oppm_demodulator: RTL and testbench
===================================

// Module: oppm_demodulator
// PURPOSE
//  Receive-side stage for the OPPM link. Recovers N-bit symbols from the pulse train
//  the OPPM modulator produces: one pulse per frame of 2**N slots, each slot L ticks.
//  Synchronizes and glitch-filters the raw pulse, acquires frame alignment from the idle
//  pattern (symbol 0 every frame), then decodes one symbol per frame and presents it.
// PARAMETERS
//  N        2  symbol width in bits; a frame has 2**N slots
//  L        4  slot length in clk ticks; L >= 2
//  TOL      1  timing tolerance in ticks; 0 <= TOL < L/2
//  MIN_HIGH 2  consecutive synchronized high samples needed to accept a pulse; must not exceed the pulse width
//  MAX_MISS 2  consecutive empty frames before lock is dropped; >= 1
// PORTS
//  clk       in   1  clock
//  rst_n     in   1  asynchronous reset, active low
//  pulse_in  in   1  raw received pulse, asynchronous to clk
//  data      out  N  decoded symbol; valid only when valid=1
//  valid     out  1  one-cycle strobe per decoded frame
//  err       out  1  qualifies valid: frame had 0 pulses or more than 1 pulse
//  locked    out  1  frame alignment held
// BEHAVIOUR
//  - Reset: data=0, valid=0, err=0, locked=0; FSM=SEARCH; all counters 0; sync flops 0.
//    Reset asserted mid-frame aborts everything immediately; re-acquisition restarts from SEARCH.
//  - Front end: pulse_in passes through a 2-flop synchronizer.
//    A qualified edge (QE) is a one-cycle event in the cycle the synchronized signal has been
//    high for MIN_HIGH consecutive samples. Only one QE per high run.
//    High runs shorter than MIN_HIGH are ignored. All timing below is in QE cycles.
//  - FRAME = (2**N)*L. Counters: tick 0..L-1 and slot 0..2**N-1.
//    tick wraps and increments slot; slot wraps to 0 after 2**N-1.
//    Counter widths are $clog2 of each range, +1 where a compare needs it. No overflow allowed.
//  - FSM states:
//    SEARCH: wait for QE -> ARM, interval counter iv=0.
//    ARM: iv increments each cycle.
//      QE with FRAME-TOL <= iv <= FRAME+TOL -> LOCKED.
//      QE outside that range -> stay ARM, iv=0 (this QE becomes the new reference).
//      iv > FRAME+TOL with no QE -> SEARCH.
//    LOCKED: on entry, the locking QE cycle counts as slot 0, tick TOL.
//      The next cycle is tick TOL+1, and so on; locked=1 from the cycle after that QE.
//  - Decode (LOCKED): the frame window is slot 0 tick 0 through slot 2**N-1 tick L-1.
//    A nominal pulse lands at tick TOL of its slot, so early arrivals up to TOL ticks and
//    late arrivals up to L-1-TOL ticks stay in the correct slot.
//    First QE in the window: capture slot into a symbol register; hit count = 1.
//    Further QEs in the same window: hit count saturates at 2; capture is unchanged.
//  - Emit: in the cycle after the last tick of the window, valid=1 for exactly one cycle.
//    hits==1: data=captured slot, err=0.
//    hits==0: data=0, err=1, miss counter +1.
//    hits>=2: data=first captured slot, err=1, miss counter cleared.
//    hits==1 also clears the miss counter.
//    data and err hold until the next emit; hits reset for the new window.
//  - Miss counter reaching MAX_MISS: that emit still occurs. Then FSM -> SEARCH and locked=0 in
//    the same cycle as the emit.
//  - A QE in the same cycle as the window rollover belongs to the new window (slot 0, tick 0).
//  - While locked there is no re-alignment; drift beyond tolerance shows up as wrong symbols,
//    err, and eventually loss of lock.
//  - valid is never asserted outside LOCKED.
// TESTING  (N=2, L=4, TOL=1, MIN_HIGH=2, MAX_MISS=2, FRAME=16, pulses 2 ticks wide)
//  1 Lock: idle pulses every 16 cycles -> locked=1 one cycle after 2nd QE. Next emits:
//    data=0, valid=1, err=0, once per 16 cycles.
//  2 Symbols: after lock, send pulses at nominal offsets for 3,1,2,0 -> data 3,1,2,0.
//    Each valid is exactly 1 cycle wide, 16 cycles apart.
//  3 Jitter: symbol 2 pulse 1 tick early, then symbol 1 pulse 2 ticks late -> data 2 then 1, err=0.
//    Symbol 0 pulse 1 tick early lands in the current frame's slot 0 -> data=0.
//  4 Glitch and double pulse: 1-cycle glitch in slot 1 plus a real pulse in slot 3 -> data=3, err=0.
//    Real pulses in slots 1 and 3 -> data=1, err=1.
//  5 Loss of lock: stop pulses -> 1st empty frame valid=1, err=1, data=0, locked=1.
//    2nd empty frame same emit, then locked=0. Resume idle pulses -> relock after 2 QEs.
//  6 Reset: assert rst_n=0 mid-window while locked -> all outputs 0 asynchronously.
//    After release, no valid before a fresh 2-pulse lock.

Source files
------------

// File: rtl/oppm_demodulator.sv
// OPPM receive stage: synchronizes and glitch-filters the raw pulse, acquires frame
// alignment from the idle pattern, then decodes one N-bit symbol per frame.
module oppm_demodulator #(
   parameter int N        = 2,
   parameter int L        = 4,
   parameter int TOL      = 1,
   parameter int MIN_HIGH = 2,
   parameter int MAX_MISS = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pulse_in,
   output logic [N-1:0] data,
   output logic         valid,
   output logic         err,
   output logic         locked
);

   localparam int SLOTS = 2**N;
   localparam int FRAME = SLOTS * L;
   localparam int TW    = $clog2(L);
   localparam int IVW   = $clog2(FRAME + TOL + 2);
   localparam int HW    = $clog2(MIN_HIGH + 1);
   localparam int MW    = $clog2(MAX_MISS + 1);

   localparam logic [TW-1:0]  TICK_LAST  = TW'(L - 1);
   localparam logic [TW-1:0]  TICK_ENTRY = TW'(TOL + 1);
   localparam logic [N-1:0]   SLOT_LAST  = N'(SLOTS - 1);
   localparam logic [IVW-1:0] IV_LO      = IVW'(FRAME - TOL);
   localparam logic [IVW-1:0] IV_HI      = IVW'(FRAME + TOL);
   localparam logic [HW-1:0]  HI_QE      = HW'(MIN_HIGH - 1);
   localparam logic [HW-1:0]  HI_SAT     = HW'(MIN_HIGH);
   localparam logic [MW-1:0]  MISS_LIMIT = MW'(MAX_MISS);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ARM    = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_next;

   logic [1:0]     r_sync;
   logic [HW-1:0]  r_hi_cnt;
   logic [IVW-1:0] r_iv;
   logic [TW-1:0]  r_tick;
   logic [N-1:0]   r_slot;
   logic [1:0]     r_hits;
   logic [N-1:0]   r_sym;
   logic [MW-1:0]  r_miss;
   logic [N-1:0]   r_data;
   logic           r_valid;
   logic           r_err;
   logic           r_locked;

   logic           w_qe;
   logic [IVW-1:0] w_iv_elapsed;
   logic           w_in_range;
   logic           w_timeout;
   logic           w_win_end;
   logic           w_hit_now;
   logic [1:0]     w_hits_upd;
   logic [N-1:0]   w_sym_upd;
   logic [MW-1:0]  w_miss_inc;
   logic           w_drop;
   logic           w_emit;
   logic           w_lock_entry;

   // Front end: two-flop synchronizer and high-run qualifier.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync   <= 2'b00;
         r_hi_cnt <= '0;
      end else begin
         r_sync <= {r_sync[0], pulse_in};
         if (!r_sync[1]) begin
            r_hi_cnt <= '0;
         end else if (r_hi_cnt != HI_SAT) begin
            r_hi_cnt <= r_hi_cnt + HW'(1);
         end
      end
   end

   // Saturating run counter means the match fires once per high run.
   assign w_qe = r_sync[1] && (r_hi_cnt == HI_QE);

   // r_iv holds elapsed-1 so the reference QE cycle itself is distance 0.
   assign w_iv_elapsed = r_iv + IVW'(1);
   assign w_in_range   = (w_iv_elapsed >= IV_LO) && (w_iv_elapsed <= IV_HI);
   assign w_timeout    = (w_iv_elapsed > IV_HI);

   assign w_win_end  = (r_tick == TICK_LAST) && (r_slot == SLOT_LAST);
   assign w_hit_now  = (r_state == ST_LOCKED) && w_qe;
   assign w_miss_inc = r_miss + MW'(1);

   // Hit bookkeeping including a QE landing in the current cycle.
   always_comb begin
      w_hits_upd = r_hits;
      w_sym_upd  = r_sym;
      if (w_hit_now) begin
         if (r_hits == 2'd0) begin
            w_hits_upd = 2'd1;
            w_sym_upd  = r_slot;
         end else begin
            w_hits_upd = 2'd2;
         end
      end
   end

   assign w_drop = (w_hits_upd == 2'd0) && (w_miss_inc >= MISS_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_SEARCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_emit       = 1'b0;
      w_lock_entry = 1'b0;
      case (r_state)
         ST_SEARCH: begin
            if (w_qe) begin
               w_state_next = ST_ARM;
            end
         end
         ST_ARM: begin
            if (w_qe && w_in_range) begin
               w_state_next = ST_LOCKED;
               w_lock_entry = 1'b1;
            end else if (!w_qe && w_timeout) begin
               w_state_next = ST_SEARCH;
            end
         end
         ST_LOCKED: begin
            if (w_win_end) begin
               w_emit = 1'b1;
               if (w_drop) begin
                  w_state_next = ST_SEARCH;
               end
            end
         end
         default: begin
            w_state_next = ST_SEARCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_iv     <= '0;
         r_tick   <= '0;
         r_slot   <= '0;
         r_hits   <= 2'd0;
         r_sym    <= '0;
         r_miss   <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_locked <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_SEARCH: begin
               if (w_qe) begin
                  r_iv <= '0;
               end
            end
            ST_ARM: begin
               if (w_qe) begin
                  r_iv <= '0;
               end else if (!w_timeout) begin
                  r_iv <= w_iv_elapsed;
               end
               // The locking QE is the idle pulse of window 0: slot 0, tick TOL.
               if (w_lock_entry) begin
                  r_tick   <= TICK_ENTRY;
                  r_slot   <= '0;
                  r_hits   <= 2'd1;
                  r_sym    <= '0;
                  r_miss   <= '0;
                  r_locked <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (r_tick == TICK_LAST) begin
                  r_tick <= '0;
                  r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + N'(1);
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
               if (w_emit) begin
                  r_valid <= 1'b1;
                  r_data  <= (w_hits_upd == 2'd0) ? '0 : w_sym_upd;
                  r_err   <= (w_hits_upd != 2'd1);
                  r_hits  <= 2'd0;
                  r_sym   <= '0;
                  if (w_hits_upd != 2'd0) begin
                     r_miss <= '0;
                  end else if (w_drop) begin
                     r_miss   <= '0;
                     r_locked <= 1'b0;
                  end else begin
                     r_miss <= w_miss_inc;
                  end
               end else begin
                  r_hits <= w_hits_upd;
                  r_sym  <= w_sym_upd;
               end
            end
            default: begin
               r_iv <= '0;
            end
         endcase
      end
   end

   assign data   = r_data;
   assign valid  = r_valid;
   assign err    = r_err;
   assign locked = r_locked;

endmodule

// File: tb/tb_oppm_demodulator.sv
// Bench for oppm_demodulator: directed frames plus random frames, checked cycle by cycle
// against a frame-level model built from the list of qualified pulse times.
module tb_oppm_demodulator;

   localparam int N        = 2;
   localparam int L        = 4;
   localparam int TOL      = 1;
   localparam int MIN_HIGH = 2;
   localparam int MAX_MISS = 2;
   localparam int S        = 1 << N;
   localparam int FRAME    = S * L;
   localparam int MAXC     = 1400;
   localparam int T0       = 10;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b0;
   logic         pulse_in = 1'b0;
   logic [N-1:0] data;
   logic         valid;
   logic         err;
   logic         locked;

   oppm_demodulator #(
      .N        (N),
      .L        (L),
      .TOL      (TOL),
      .MIN_HIGH (MIN_HIGH),
      .MAX_MISS (MAX_MISS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pulse_in (pulse_in),
      .data     (data),
      .valid    (valid),
      .err      (err),
      .locked   (locked)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   bit sched    [MAXC];
   bit e_valid  [MAXC];
   bit e_err    [MAXC];
   bit e_locked [MAXC];
   int e_data   [MAXC];
   int em_d     [MAXC];
   bit em_e     [MAXC];
   int qe[$];

   task automatic chk(input string tag, input int got, input int exp_v);
      total++;
      if (got != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
      end
   endtask

   task automatic clear_phase();
      for (int n = 0; n < MAXC; n++) begin
         sched[n]    = 1'b0;
         e_valid[n]  = 1'b0;
         e_err[n]    = 1'b0;
         e_locked[n] = 1'b0;
         e_data[n]   = 0;
         em_d[n]     = 0;
         em_e[n]     = 1'b0;
      end
      qe.delete();
   endtask

   task automatic add_pulse(input int start, input int width);
      for (int n = start; n < start + width; n++)
         if (n >= 0 && n < MAXC) sched[n] = 1'b1;
   endtask

   // Symbol s in frame k, shifted by j ticks; pulses are 2 ticks wide.
   task automatic sym(input int k, input int s, input int j);
      add_pulse(T0 + k * FRAME + s * L + j, 2);
   endtask

   task automatic rand_frame(input int k);
      int r, s, s2;
      r = int'($urandom_range(0, 9));
      s = int'($urandom_range(0, S - 1));
      if (r == 0) begin
         // empty frame
      end else if (r == 1) begin
         s2 = (s + int'($urandom_range(1, S - 1))) % S;
         sym(k, s, 0);
         sym(k, s2, 0);
      end else if (r == 2) begin
         add_pulse(T0 + k * FRAME + ((s + 2) % S) * L + 1, 1);
         sym(k, s, 0);
      end else begin
         sym(k, s, int'($urandom_range(0, L - 1)) - TOL);
      end
   endtask

   // Reference: a high run of >= MIN_HIGH cycles driven from cycle st is qualified
   // at st+MIN_HIGH+1 (two sync stages). Alignment and decode work on those times.
   task automatic build_model(input int horizon);
      int run, i, rf, q, w, k, hits, first, miss, e, cur_d;
      bit cur_e;
      run = 0;
      for (int n = 0; n < MAXC; n++) begin
         run = sched[n] ? run + 1 : 0;
         if (sched[n] && run == MIN_HIGH) qe.push_back(n + 2);
      end
      i = 0;
      while (i < qe.size()) begin
         rf = qe[i];
         i++;
         while (i < qe.size() && !((qe[i] - rf >= FRAME - TOL) && (qe[i] - rf <= FRAME + TOL))) begin
            rf = qe[i];
            i++;
         end
         if (i >= qe.size()) break;
         q = qe[i];
         i++;
         w = q - TOL;
         hits = 1; first = 0; miss = 0; k = 0;
         forever begin
            e = w + (k + 1) * FRAME;
            if (e > horizon) begin
               for (int n = q + 1; n <= horizon; n++) e_locked[n] = 1'b1;
               i = qe.size();
               break;
            end
            while (i < qe.size() && qe[i] < e) begin
               if (hits == 0) first = (qe[i] - w - k * FRAME) / L;
               if (hits < 2) hits++;
               i++;
            end
            e_valid[e] = 1'b1;
            em_d[e]    = (hits == 0) ? 0 : first;
            em_e[e]    = (hits != 1);
            miss       = (hits == 0) ? miss + 1 : 0;
            if (miss >= MAX_MISS) begin
               for (int n = q + 1; n < e; n++) e_locked[n] = 1'b1;
               break;
            end
            hits = 0;
            k++;
         end
      end
      cur_d = 0;
      cur_e = 1'b0;
      for (int n = 0; n < MAXC; n++) begin
         if (e_valid[n]) begin
            cur_d = em_d[n];
            cur_e = em_e[n];
         end
         e_data[n] = cur_d;
         e_err[n]  = cur_e;
      end
   endtask

   // Cycle n starts at posedge n; outputs are sampled 1 time unit later.
   task automatic run_phase(input string ph, input int horizon);
      for (int n = 0; n <= horizon; n++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s valid@%0d", ph, n), int'(valid), int'(e_valid[n]));
         chk($sformatf("%s locked@%0d", ph, n), int'(locked), int'(e_locked[n]));
         chk($sformatf("%s data@%0d", ph, n), int'(data), e_data[n]);
         chk($sformatf("%s err@%0d", ph, n), int'(err), int'(e_err[n]));
         if (valid || e_valid[n])
            $display("%s cyc %0d: valid=%0d data=%0d err=%0d locked=%0d (model data=%0d err=%0d)",
                     ph, n, valid, data, err, locked, e_data[n], e_err[n]);
         pulse_in = sched[n];
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " data"},   int'(data),   0);
      chk({tag, " valid"},  int'(valid),  0);
      chk({tag, " err"},    int'(err),    0);
      chk({tag, " locked"}, int'(locked), 0);
   endtask

   initial begin
      int ra, len_b;

      repeat (2) @(posedge clk);
      #2;
      check_zero("por");
      #1 rst_n = 1'b1;

      // Phase A: lock, symbols, jitter, glitch/double, loss and relock, random, idle.
      clear_phase();
      for (int k = 0; k < 3; k++) sym(k, 0, 0);
      sym(3, 3, 0); sym(4, 1, 0); sym(5, 2, 0); sym(6, 0, 0);
      sym(7, 2, -1); sym(8, 1, 2); sym(9, 0, -1);
      add_pulse(T0 + 10 * FRAME + 1 * L + 1, 1);
      sym(10, 3, 0);
      sym(11, 1, 0); sym(11, 3, 0);
      sym(12, 0, 0);
      for (int k = 15; k < 19; k++) sym(k, 0, 0);
      for (int k = 19; k < 49; k++) rand_frame(k);
      for (int k = 49; k < 55; k++) sym(k, 0, 0);
      ra = T0 + 53 * FRAME + 3 + 5;
      build_model(ra);
      run_phase("A", ra);

      // Asynchronous reset in the middle of a locked window.
      #1 rst_n = 1'b0;
      pulse_in = 1'b0;
      #1 check_zero("async_rst");
      repeat (3) @(posedge clk);
      #2;
      check_zero("held_rst");
      rst_n = 1'b1;

      // Phase B: leading glitch, fresh lock, random frames, idle tail.
      clear_phase();
      add_pulse(3, 1);
      for (int k = 0; k < 4; k++) sym(k, 0, 0);
      for (int k = 4; k < 24; k++) rand_frame(k);
      for (int k = 24; k < 28; k++) sym(k, 0, 0);
      len_b = T0 + 28 * FRAME + 20;
      build_model(len_b - 1);
      run_phase("B", len_b - 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
